// File: rtl/seq_divider_16bit_pkg.sv
// Shared definitions for the sequential 16-bit divider: operand width,
// iteration-counter width and FSM state encodings.
package seq_divider_16bit_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage : seq_divider_16bit_pkg

// File: rtl/seq_divider_16bit_sub.sv
// cla_subtractor_16: 16-bit carry-lookahead adder with a lookahead carry unit,
// wired as a subtractor (diff = a - b via a + ~b + 1).
// Ports:
//   a          in  16  minuend
//   b          in  16  subtrahend
//   diff       out 16  a - b (modulo 2^16)
//   no_borrow  out 1   adder carry-out; 1 when a >= b
module cla_subtractor_16
  import seq_divider_16bit_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic [DIV_WIDTH-1:0] diff,
  output logic                 no_borrow
);

  logic [DIV_WIDTH-1:0] b_n;
  logic [DIV_WIDTH-1:0] g;
  logic [DIV_WIDTH-1:0] p;
  logic [DIV_WIDTH-1:0] c;
  logic [3:0]           grp_g;
  logic [3:0]           grp_p;
  logic [4:0]           grp_c;

  // Bit generate/propagate, 4-bit group lookahead, LCU across groups, sum.
  always_comb begin
    b_n = ~b;
    g   = a & b_n;
    p   = a ^ b_n;
    c   = '0;

    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end

    // Lookahead carry unit; c_in is tied high for subtraction.
    grp_c[0] = 1'b1;
    grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & grp_c[0]);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);

    for (int k = 0; k < 4; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end

    diff      = p ^ c;
    no_borrow = grp_c[4];
  end

endmodule : cla_subtractor_16

// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: multi-cycle unsigned restoring divider, one quotient bit
// per cycle, trial subtraction through a CLA subtractor.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        request, sampled only in IDLE
//   dividend     captured on accepted start
//   divisor      captured on accepted start
//   busy         high in RUN and DONE
//   done         one-cycle pulse, results valid from this cycle
//   quotient     held until the next op's done
//   remainder    held until the next op's done
//   div_by_zero  set with done when divisor was 0
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             busy_d, done_d, dbz_d;

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             accept;

  // Partial remainder shifted left with the next dividend bit.
  assign sh     = {rem_q, quo_q[WIDTH-1]};
  // A set sh MSB means sh > divisor even though the 16-bit subtract borrows.
  assign accept = sh[WIDTH] | no_borrow;

  cla_subtractor_16 u_sub (
    .a         (sh[WIDTH-1:0]),
    .b         (dvs_q),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath and output next values.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = div_by_zero;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = '0;
            quo_d   = dividend;
            dvs_d   = divisor;
            cnt_d   = CNT_W'(WIDTH);
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        rem_d = accept ? diff : sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], accept};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_DONE;
          quotient_d  = quo_d;
          remainder_d = rem_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dbz_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule : seq_divider_16bit

// File: tb/tb_seq_divider_16bit.sv
// Directed and randomized self-checking bench for seq_divider_16bit.
module tb_seq_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider_16bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge; afterwards the bench sits in cycle 1 of the op.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Bounded wait for done; lat counts the cycle number in which done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Full op: launch, wait, check results and latency, step into the next IDLE cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edbz, input int elat);
    int lat;
    launch(a, b);
    wait_done(lat);
    check({tag, "_lat"},  lat,         elat);
    check({tag, "_q"},    quotient,    eq);
    check({tag, "_r"},    remainder,   er);
    check({tag, "_dbz"},  div_by_zero, edbz);
    check({tag, "_busy"}, busy,        1'b1);
    tick();
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int n_done;
    int done_cyc;
    int lat;
    logic [15:0] a, b, eq, er;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q",    quotient, 16'h0);
    check("rst_r",    remainder, 16'h0);
    check("rst_dbz",  div_by_zero, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: basic
    run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);

    // 2: extremes, including the shifted-remainder MSB path
    run_op("ffff_1",    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
    run_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);
    run_op("8000_ffff", 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17);
    run_op("ffff_8001", 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 17);

    // 3: divide by zero, then clearing
    run_op("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
    launch(16'd9, 16'd3);
    check("dbz_clr_on_start", div_by_zero, 1'b0);
    wait_done(lat);
    check("d9_3_lat", lat, 17);
    check("d9_3_q", quotient, 16'd3);
    check("d9_3_r", remainder, 16'd0);
    tick();

    // 4: starts during RUN and DONE are dropped
    launch(16'd3, 16'd10);
    n_done   = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      start = (cyc == 4 || cyc == 17);
      if (start) begin
        dividend = 16'd50;
        divisor  = 16'd7;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("d3_10_q", quotient, 16'd0);
        check("d3_10_r", remainder, 16'd3);
      end
      if (cyc == 17) check("d3_10_busy_done", busy, 1'b1);
      if (cyc == 18) check("d3_10_busy_after", busy, 1'b0);
      tick();
    end
    start = 1'b0;
    check("d3_10_ndone", n_done, 1);
    check("d3_10_donecyc", done_cyc, 17);
    check("d3_10_q_hold", quotient, 16'd0);

    // 6: back-to-back start in the first IDLE cycle; old results hold until new done
    run_op("b2b_a", 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 17);
    launch(16'd7001, 16'd100);
    check("b2b_busy", busy, 1'b1);
    check("b2b_hold_q1", quotient, 16'd22);
    check("b2b_hold_r1", remainder, 16'd2);
    for (int i = 0; i < 8; i++) tick();
    check("b2b_hold_q9", quotient, 16'd22);
    check("b2b_hold_r9", remainder, 16'd2);
    wait_done(lat);
    check("b2b_lat", lat + 8, 17);
    check("b2b_q", quotient, 16'd70);
    check("b2b_r", remainder, 16'd1);
    tick();

    // 5: reset mid-operation
    launch(16'd1000, 16'd3);
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_q", quotient, 16'h0);
    check("midrst_r", remainder, 16'h0);
    check("midrst_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    tick();
    check("midrst_stays_idle", {busy, done}, 2'b00);
    run_op("d1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17);

    // Random pairs against a behavioural model, occasionally zero / small divisors.
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0;
        1, 2:    b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      if (b == 16'h0) begin
        eq = 16'hFFFF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_op("rnd", a, b, eq, er, (b == 16'h0), (b == 16'h0) ? 1 : 17);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_divider_16bit
